// File: rtl/nibble_serial_add.sv
// Purpose: adds two NIBBLES*4-bit operands one nibble per clock, rippling
//          the carry between nibbles through a one-bit carry register.
// Latency: out_valid rises exactly NIBBLES edges after the accept edge.
// Backpressure: the result is held in DONE until out_ready=1; start is only
//               accepted while in_ready=1 and is never queued.
//
// Ports:
//   clk        rising-edge clock for all state
//   rst        asynchronous active-high reset
//   start      request an add; sampled only while in_ready=1
//   in_ready   idle and able to accept start
//   a, b       operands (W = 4*NIBBLES bits), captured on the accept edge
//   out_valid  sum/cout hold a completed result
//   out_ready  consumer takes the result; only meaningful while out_valid=1
//   sum        low W bits of a+b
//   cout       carry out of the most significant nibble
module nibble_serial_add #(
  parameter int NIBBLES = 4  // legal range 2..8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   in_ready,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NIBBLES-1:0]   sum,
  output logic                   cout
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = $clog2(NIBBLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [W-1:0]    sum_q;
  logic [IW-1:0]   idx;
  logic            carry;
  logic            cout_q;

  logic [3:0]      nib_a;
  logic [3:0]      nib_b;
  logic [4:0]      nib_sum;
  logic            last_nib;

  // Datapath reads only the captured operands, so nothing on a/b can reach
  // an output combinationally and later changes on a/b are ignored.
  always_comb begin
    nib_a    = a_q[4*idx +: 4];
    nib_b    = b_q[4*idx +: 4];
    nib_sum  = {1'b0, nib_a} + {1'b0, nib_b} + {4'b0000, carry};
    last_nib = (idx == IW'(NIBBLES - 1));
  end

  // Single FSM block; in_ready/out_valid are registered alongside state so
  // they always match the state encoding.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      sum_q     <= '0;
      idx       <= '0;
      carry     <= 1'b0;
      cout_q    <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q      <= a;
            b_q      <= b;
            sum_q    <= '0;
            idx      <= '0;
            carry    <= 1'b0;
            state    <= RUN;
            in_ready <= 1'b0;
          end
        end

        RUN: begin
          sum_q[4*idx +: 4] <= nib_sum[3:0];
          carry             <= nib_sum[4];
          idx               <= idx + 1'b1;
          if (last_nib) begin
            cout_q    <= nib_sum[4];
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end

        DONE: begin
          // Returning to IDLE here means a start seen on this same edge is
          // not taken; acceptance happens on a later edge from IDLE.
          if (out_ready) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
          end
        end

        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  // sum/cout keep their values through IDLE until the next accept.
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_nibble_serial_add.sv
// Purpose: directed self-checking bench for nibble_serial_add (NIBBLES=4).
// Latency: expects out_valid exactly 4 edges after each accept edge.
// Backpressure: exercises held results, start ignored in RUN/DONE and on the
//               DONE exit edge, and reset in the middle of an operation.
module tb_nibble_serial_add;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  sum;
  logic          cout;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  nibble_serial_add #(.NIBBLES(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive operands with start for one edge (the accept edge).
  task automatic launch(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_idle_before"}, in_ready, 1);
    a     = av;
    b     = bv;
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_accepted"}, in_ready, 0);
  endtask

  // Four RUN edges; out_valid must be low until the last one.
  task automatic run_to_done(input string tag, input bit chk_carry);
    for (int i = 1; i <= N; i++) begin
      tick();
      check($sformatf("%s_vld_edge%0d", tag, i), out_valid, (i == N) ? 1 : 0);
      if (chk_carry)
        check($sformatf("%s_carry_edge%0d", tag, i), dut.carry, 1);
    end
  endtask

  task automatic expect_result(input string tag, input logic [W-1:0] s, input logic c);
    check({tag, "_sum"}, sum, s);
    check({tag, "_cout"}, cout, c);
  endtask

  // Hand the result off, then confirm IDLE and that sum/cout are retained.
  task automatic handoff(input string tag, input logic [W-1:0] s, input logic c);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_hand_rdy"}, in_ready, 1);
    check({tag, "_hand_vld"}, out_valid, 0);
    tick();
    check({tag, "_keep_sum"}, sum, s);
    check({tag, "_keep_cout"}, cout, c);
  endtask

  initial begin
    int episodes;
    rst       = 1'b1;
    start     = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;

    // Reset state
    tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    tick();
    rst = 1'b0;

    // Basic add; accepted on the first edge after reset release
    launch("basic", 16'h1234, 16'h4321);
    run_to_done("basic", 1'b0);
    expect_result("basic", 16'h5555, 1'b0);
    handoff("basic", 16'h5555, 1'b0);

    // Full carry ripple: carry register is 1 after every RUN edge
    launch("ripple", 16'hFFFF, 16'h0001);
    run_to_done("ripple", 1'b1);
    expect_result("ripple", 16'h0000, 1'b1);
    handoff("ripple", 16'h0000, 1'b1);

    // Reset after the 2nd RUN edge; cout is 1 beforehand so the clear shows
    launch("midrst", 16'hABCD, 16'h1111);
    tick();
    tick();
    check("midrst_run_vld", out_valid, 0);
    #1 rst = 1'b1;
    #1;
    check("midrst_async_rdy", in_ready, 1);
    check("midrst_async_vld", out_valid, 0);
    check("midrst_async_sum", sum, 0);
    check("midrst_async_cout", cout, 0);
    tick();
    check("midrst_held_vld", out_valid, 0);
    rst = 1'b0;
    launch("after_rst", 16'h0001, 16'h0002);
    run_to_done("after_rst", 1'b0);
    expect_result("after_rst", 16'h0003, 1'b0);
    handoff("after_rst", 16'h0003, 1'b0);

    // MSB overflow wraps; carry out of the top nibble only
    launch("msb_ovf", 16'h8000, 16'h8000);
    run_to_done("msb_ovf", 1'b0);
    expect_result("msb_ovf", 16'h0000, 1'b1);
    handoff("msb_ovf", 16'h0000, 1'b1);

    launch("mid_ripple", 16'h0F0F, 16'h00F1);
    run_to_done("mid_ripple", 1'b0);
    expect_result("mid_ripple", 16'h1000, 1'b0);
    handoff("mid_ripple", 16'h1000, 1'b0);

    // Backpressure: hold 3 cycles, then exit with start already high
    launch("bp", 16'h0102, 16'h0304);
    run_to_done("bp", 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("bp_hold%0d_vld", i), out_valid, 1);
      check($sformatf("bp_hold%0d_sum", i), sum, 16'h0406);
      check($sformatf("bp_hold%0d_cout", i), cout, 0);
    end
    out_ready = 1'b1;
    start     = 1'b1;
    a         = 16'h0005;
    b         = 16'h0006;
    tick();
    out_ready = 1'b0;
    check("bp_exit_rdy", in_ready, 1);
    check("bp_exit_vld", out_valid, 0);
    check("bp_exit_sum", sum, 16'h0406);
    tick();
    start = 1'b0;
    check("bp_next_accept", in_ready, 0);
    run_to_done("bp_next", 1'b0);
    expect_result("bp_next", 16'h000B, 1'b0);
    handoff("bp_next", 16'h000B, 1'b0);

    // Ignored inputs: start, a/b changes and out_ready during RUN
    launch("ign", 16'h1111, 16'h2222);
    tick();
    start     = 1'b1;
    out_ready = 1'b1;
    a         = 16'hFFFF;
    b         = 16'hFFFF;
    tick();
    start     = 1'b0;
    out_ready = 1'b0;
    tick();
    check("ign_vld_edge3", out_valid, 0);
    tick();
    check("ign_vld_edge4", out_valid, 1);
    expect_result("ign", 16'h3333, 1'b0);
    handoff("ign", 16'h3333, 1'b0);
    episodes = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid) episodes++;
    end
    check("ign_extra_episodes", episodes, 0);
    check("ign_final_rdy", in_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
